// File: rtl/ring_mon_pkg.sv
// Shared types and the ring-counter next-state rule used by the sequence monitor.
package ring_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        FAULT = 2'd2
    } mon_state_t;

    localparam int NBITS_COUNT_DEF = 4;
    localparam int RING_MAX        = 32;

    // Works on a RING_MAX-wide container so one function serves any ring width up to RING_MAX.
    function automatic logic [RING_MAX-1:0] next_ring(input logic [RING_MAX-1:0] prev,
                                                      input logic                load_q,
                                                      input int unsigned         nbits);
        logic [RING_MAX-1:0] mask;
        logic [RING_MAX-1:0] msb_shift;
        mask      = (RING_MAX'(1) << nbits) - RING_MAX'(1);
        msb_shift = prev >> (nbits - 1);
        if (load_q || msb_shift[0]) begin
            return RING_MAX'(1);
        end
        return (prev << 1) & mask;
    endfunction

endpackage

// File: rtl/ring_mon_onehot_encoder.sv
// Combinational classifier for the sampled ring value: zero, one-hot, and hot-bit index.
module onehot_encoder #(
    parameter int NBITS = 4
) (
    input  logic [NBITS-1:0]         in_i,
    output logic                     is_onehot_o,
    output logic                     is_zero_o,
    output logic [$clog2(NBITS)-1:0] index_o
);

    always_comb begin
        is_zero_o   = (in_i == '0);
        is_onehot_o = !is_zero_o && ((in_i & (in_i - NBITS'(1))) == '0);
        index_o     = '0;
        // Index is only meaningful when is_onehot_o is set.
        for (int i = 0; i < NBITS; i++) begin
            if (in_i[i]) begin
                index_o = index_o | ($clog2(NBITS))'(i);
            end
        end
    end

endmodule

// File: rtl/ring_sequence_monitor.sv
// Passive checker for a walking-one ring counter: locks on, tracks position and laps,
// and reports step violations with a sticky flag and a saturating error count.
module ring_sequence_monitor
    import ring_mon_pkg::*;
#(
    parameter int NBITS_COUNT = NBITS_COUNT_DEF,
    parameter int NBITS_LAP   = 8,
    parameter int NBITS_ERR   = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           load_i,
    input  logic                           clear_err_i,
    input  logic [NBITS_COUNT-1:0]         count_in_i,
    output logic                           locked_o,
    output logic [$clog2(NBITS_COUNT)-1:0] position_o,
    output logic [NBITS_LAP-1:0]           laps_o,
    output logic                           lap_done_o,
    output logic                           step_err_o,
    output logic                           err_sticky_o,
    output logic [NBITS_ERR-1:0]           err_count_o
);

    localparam int IW = $clog2(NBITS_COUNT);

    mon_state_t             state_q, state_d;
    logic [NBITS_COUNT-1:0] prev_q;
    logic                   load_q;
    logic                   locked_q, locked_d;
    logic [IW-1:0]          position_q, position_d;
    logic [NBITS_LAP-1:0]   laps_q, laps_d;
    logic                   lap_done_q, lap_done_d;
    logic                   step_err_q, step_err_d;
    logic                   err_sticky_q, err_sticky_d;
    logic [NBITS_ERR-1:0]   err_count_q, err_count_d;

    logic                   is_onehot, is_zero;
    logic [IW-1:0]          hot_index;
    logic [NBITS_COUNT-1:0] expected;

    onehot_encoder #(.NBITS(NBITS_COUNT)) u_enc (
        .in_i        (count_in_i),
        .is_onehot_o (is_onehot),
        .is_zero_o   (is_zero),
        .index_o     (hot_index)
    );

    assign expected = NBITS_COUNT'(next_ring(RING_MAX'(prev_q), load_q, NBITS_COUNT));

    always_comb begin
        state_d      = state_q;
        position_d   = '0;
        laps_d       = laps_q;
        lap_done_d   = 1'b0;
        step_err_d   = 1'b0;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;

        unique case (state_q)
            IDLE: begin
                if (is_onehot) begin
                    state_d    = LOCK;
                    position_d = hot_index;
                    laps_d     = '0;
                end else if (!is_zero) begin
                    state_d    = FAULT;
                    step_err_d = 1'b1;
                end
            end
            LOCK: begin
                if (count_in_i == expected) begin
                    position_d = hot_index;
                    if (load_q) begin
                        laps_d = '0;
                    end else if (prev_q[NBITS_COUNT-1]) begin
                        laps_d     = laps_q + NBITS_LAP'(1);
                        lap_done_d = 1'b1;
                    end
                end else begin
                    state_d    = FAULT;
                    step_err_d = 1'b1;
                end
            end
            FAULT: begin
                // Only an explicit reload gets us back; further bad steps are not re-reported.
                if (load_q && count_in_i == NBITS_COUNT'(1)) begin
                    state_d    = LOCK;
                    position_d = hot_index;
                    laps_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        locked_d = (state_d == LOCK);

        if (step_err_d) begin
            err_sticky_d = 1'b1;
            if (clear_err_i) begin
                err_count_d = NBITS_ERR'(1);
            end else if (!(&err_count_q)) begin
                err_count_d = err_count_q + NBITS_ERR'(1);
            end
        end else if (clear_err_i) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            load_q       <= 1'b0;
            locked_q     <= 1'b0;
            position_q   <= '0;
            laps_q       <= '0;
            lap_done_q   <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= count_in_i;
            load_q       <= load_i;
            locked_q     <= locked_d;
            position_q   <= position_d;
            laps_q       <= laps_d;
            lap_done_q   <= lap_done_d;
            step_err_q   <= step_err_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign locked_o     = locked_q;
    assign position_o   = position_q;
    assign laps_o       = laps_q;
    assign lap_done_o   = lap_done_q;
    assign step_err_o   = step_err_q;
    assign err_sticky_o = err_sticky_q;
    assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_ring_sequence_monitor.sv
// Ring counter + forced-value mux driving the monitor; a position-level reference model
// feeds a scoreboard queue that a separate monitor thread drains every cycle.
module tb_ring_sequence_monitor;

    localparam int N = 4;

    typedef struct packed {
        logic       locked;
        logic [1:0] position;
        logic [7:0] laps;
        logic       lap_done;
        logic       step_err;
        logic       sticky;
        logic [3:0] errc;
    } out_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load = 1'b0;
    logic         clear_err = 1'b0;
    logic         force_en = 1'b0;
    logic [N-1:0] force_val = '0;
    logic [N-1:0] ring_cnt;
    logic [N-1:0] count_in;

    logic         locked, lap_done, step_err, err_sticky;
    logic [1:0]   position;
    logic [7:0]   laps;
    logic [3:0]   err_count;

    int checks = 0;
    int errors = 0;
    out_t exp_q[$];

    always #5 clk = ~clk;

    // Reference ring counter: Count <= load ? 1 : rotate-left.
    always @(posedge clk) begin
        if (reset)     ring_cnt <= '0;
        else if (load) ring_cnt <= 4'b0001;
        else           ring_cnt <= ring_cnt[N-1] ? 4'b0001 : (ring_cnt << 1);
    end

    assign count_in = force_en ? force_val : ring_cnt;

    ring_sequence_monitor #(.NBITS_COUNT(N), .NBITS_LAP(8), .NBITS_ERR(4)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .load_i       (load),
        .clear_err_i  (clear_err),
        .count_in_i   (count_in),
        .locked_o     (locked),
        .position_o   (position),
        .laps_o       (laps),
        .lap_done_o   (lap_done),
        .step_err_o   (step_err),
        .err_sticky_o (err_sticky),
        .err_count_o  (err_count)
    );

    // Reference model in terms of "mode" and hot-bit position, not bit vectors.
    localparam int M_IDLE = 0, M_LOCK = 1, M_FAULT = 2;
    int   m_mode, m_pos, m_laps, m_errc;
    bit   m_sticky, m_prev_load;

    always @(posedge clk) begin : model
        out_t e;
        int   ones, idx, nxt;
        bit   viol, lapd;
        ones = $countones(count_in);
        idx  = 0;
        for (int i = 0; i < N; i++) if (count_in[i]) idx = i;
        viol = 0;
        lapd = 0;
        if (reset) begin
            m_mode = M_IDLE; m_pos = 0; m_laps = 0; m_errc = 0; m_sticky = 0; m_prev_load = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (ones == 1) begin m_mode = M_LOCK; m_pos = idx; m_laps = 0; end
                    else if (ones > 1) begin m_mode = M_FAULT; viol = 1; end
                end
                M_LOCK: begin
                    nxt = m_prev_load ? 0 : (m_pos + 1) % N;
                    if (count_in == 4'(1 << nxt)) begin
                        if (m_prev_load) m_laps = 0;
                        else if (m_pos == N - 1) begin m_laps = (m_laps + 1) % 256; lapd = 1; end
                        m_pos = nxt;
                    end else begin
                        m_mode = M_FAULT; viol = 1;
                    end
                end
                default: begin
                    if (m_prev_load && count_in == 4'b0001) begin m_mode = M_LOCK; m_pos = 0; m_laps = 0; end
                end
            endcase
            if (viol) begin
                m_sticky = 1;
                m_errc   = clear_err ? 1 : (m_errc == 15 ? 15 : m_errc + 1);
            end else if (clear_err) begin
                m_sticky = 0;
                m_errc   = 0;
            end
            m_prev_load = load;
        end
        e.locked   = (m_mode == M_LOCK);
        e.position = (m_mode == M_LOCK) ? 2'(m_pos) : 2'd0;
        e.laps     = 8'(m_laps);
        e.lap_done = lapd;
        e.step_err = viol;
        e.sticky   = m_sticky;
        e.errc     = 4'(m_errc);
        exp_q.push_back(e);
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    task automatic monitor_loop();
        out_t a, e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {locked, position, laps, lap_done, step_err, err_sticky, err_count};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard at %0t: actual lk=%0b pos=%0d laps=%0d ld=%0b se=%0b st=%0b ec=%0d required lk=%0b pos=%0d laps=%0d ld=%0b se=%0b st=%0b ec=%0d",
                             $time, a.locked, a.position, a.laps, a.lap_done, a.step_err, a.sticky, a.errc,
                             e.locked, e.position, e.laps, e.lap_done, e.step_err, e.sticky, e.errc);
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic stimulus();
        // 1: reset then idle with counter halted
        reset = 1; tick(2); reset = 0; tick(10);
        chk("idle_locked", int'(locked), 0);
        chk("idle_err_count", int'(err_count), 0);
        chk("idle_laps", int'(laps), 0);

        // 2: load and free-run through two laps
        load = 1; tick(1); load = 0; tick(9);
        chk("run_locked", int'(locked), 1);
        chk("run_laps", int'(laps), 2);
        chk("run_position", int'(position), 0);

        // 3: wrong step while locked, then relock
        force_en = 1; force_val = 4'b0100; tick(1); force_en = 0;
        chk("fault_step_err", int'(step_err), 1);
        chk("fault_err_count", int'(err_count), 1);
        chk("fault_locked", int'(locked), 0);
        tick(1);
        chk("fault_single_pulse", int'(step_err), 0);
        tick(6);
        load = 1; tick(1); load = 0; tick(2);
        chk("relock_locked", int'(locked), 1);
        chk("relock_laps", int'(laps), 0);

        // 4: non-onehot in IDLE, then saturate the error counter
        reset = 1; tick(1); reset = 0; tick(2);
        force_en = 1; force_val = 4'b0110; tick(1); force_en = 0;
        chk("idle_fault_err_count", int'(err_count), 1);
        for (int k = 0; k < 20; k++) begin
            load = 1; tick(1); load = 0; tick(1);
            force_en = 1; force_val = 4'b0110; tick(1); force_en = 0; tick(1);
        end
        chk("sat_err_count", int'(err_count), 15);
        chk("sat_sticky", int'(err_sticky), 1);

        // 5: clear collides with a violation, then clear alone
        load = 1; tick(1); load = 0; tick(1);
        clear_err = 1; force_en = 1; force_val = 4'b0110; tick(1); clear_err = 0; force_en = 0;
        chk("clr_vs_viol_sticky", int'(err_sticky), 1);
        chk("clr_vs_viol_count", int'(err_count), 1);
        clear_err = 1; tick(1); clear_err = 0;
        chk("clr_sticky", int'(err_sticky), 0);
        chk("clr_count", int'(err_count), 0);

        // 6: reset while locked with laps=5, then relock
        load = 1; tick(1); load = 0; tick(22);
        chk("pre_reset_laps", int'(laps), 5);
        reset = 1; tick(1); reset = 0;
        chk("post_reset_locked", int'(locked), 0);
        chk("post_reset_laps", int'(laps), 0);
        tick(3);
        load = 1; tick(1); load = 0; tick(5);
        chk("after_reset_laps", int'(laps), 1);
        chk("after_reset_locked", int'(locked), 1);

        // Randomized traffic against the reference model
        for (int k = 0; k < 600; k++) begin
            reset     = ($urandom_range(0, 63) == 0);
            load      = ($urandom_range(0, 9) == 0);
            clear_err = ($urandom_range(0, 15) == 0);
            force_en  = ($urandom_range(0, 11) == 0);
            force_val = 4'($urandom_range(0, 15));
            tick(1);
        end
        reset = 0; load = 0; clear_err = 0; force_en = 0;
        tick(3);
    endtask

    initial begin
        fork
            monitor_loop();
            stimulus();
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
